// File: rtl/stream_width_down.sv
// Valid/ready width down-converter: one IN_WIDTH word out as RATIO OUT_WIDTH beats, last beat flagged (MSB-first order with STREAM_WIDTH_DOWN_MSB_FIRST_EN).
// Latency: first beat valid the cycle after the word is accepted; back-to-back words run with no bubble.
// Backpressure: beat held stable while out_ready=0; in_ready only while empty or the last beat is leaving.
module stream_width_down #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

    generate
        if (OUT_WIDTH <= 0 || IN_WIDTH <= 0 || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_bad_width
            $error("stream_width_down: IN_WIDTH must be a positive integer multiple of OUT_WIDTH");
        end
    endgenerate

    logic [IN_WIDTH-1:0] hold;
    logic [CNT_W-1:0]    cnt;
    logic                full;
    logic [CNT_W-1:0]    sel;
    logic                last_beat;
    logic                out_fire;
    logic                in_fire;

    assign last_beat = full && (cnt == LAST_CNT);
    assign out_valid = full;
    assign out_last  = last_beat;
    assign out_fire  = out_valid && out_ready;
    // Reloading on the last-beat edge is what removes the inter-word bubble.
    assign in_ready  = !full || (out_fire && last_beat);
    assign in_fire   = in_valid && in_ready;

`ifdef STREAM_WIDTH_DOWN_MSB_FIRST_EN
    assign sel = LAST_CNT - cnt;
`else
    assign sel = cnt;
`endif

    // Output is forced to zero while empty so stale words never leak onto the bus.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (full && sel == CNT_W'(i)) begin
                out_data = hold[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold <= '0;
            cnt  <= '0;
            full <= 1'b0;
        end else if (in_fire) begin
            hold <= in_data;
            cnt  <= '0;
            full <= 1'b1;
        end else if (out_fire) begin
            if (last_beat) begin
                cnt  <= '0;
                full <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule
